store_buffer: RTL and testbench
===============================

# store_buffer

Parametrised store path between execute and the data-memory port. Accepts one store per handshake (base, immediate, data, func3) and computes the effective address. Lane-aligns the data, generates byte strobes and queues the result in a DEPTH-entry in-order FIFO. Drains the FIFO to memory over a valid/ready port, splitting stores that cross a word boundary into two beats, or rejecting them with an error pulse.

## Interface
- XLEN, 32: data/address width; 32 or 64. NB = XLEN/8 bytes per beat, OB = log2(NB).
- DEPTH, 4: FIFO entries; power of 2, ≥2.
- SPLIT_MISALIGNED, 1: 1 = split word-crossing stores into two beats; 0 = reject them.
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- in_valid  in  1  store request valid.
- in_ready  out  1  buffer can accept; equals (count < DEPTH), independent of mem_ready.
- in_base  in  XLEN  base register value.
- in_imm  in  XLEN  sign-extended offset.
- in_data  in  XLEN  store data, right-justified.
- in_func3  in  3  000 SB, 001 SH, 010 SW, 011 SD (legal only when XLEN=64).
- mem_valid  out  1  beat valid.
- mem_ready  in  1  memory accepts beat.
- mem_addr  out  XLEN  beat address, low OB bits zero.
- mem_wdata  out  XLEN  lane-aligned write data.
- mem_wstrb  out  NB  byte enables.
- err_valid  out  1  one-cycle error pulse.
- err_cause  out  2  01 misaligned-crossing, 10 illegal func3.
- err_addr  out  XLEN  effective address of the rejected store.
- count  out  clog2(DEPTH+1)  occupied entries.
- empty  out  1  count == 0.

## Operation
- Accept occurs when in_valid & in_ready. Nothing is sampled otherwise.
- Effective address: ea = in_base + in_imm, modulo 2^XLEN (wraps).
- Size in bytes: sz = 1 << func3[1:0]. Offset: off = ea[OB-1:0].
- Data is masked to sz bytes and shifted left by 8*off into a 2*NB-byte vector D.
- Strobe: S = ((1<<sz)-1) << off, 2*NB bits.
- crossing = (off + sz > NB). Misaligned stores inside one word (e.g. SH at offset 1) are a normal single beat.
- Illegal func3 (bit2 set, or 011 with XLEN=32): the request is accepted and dropped, with err cause 10.
- crossing with SPLIT_MISALIGNED=0: the request is accepted and dropped, with err cause 01.
- All other stores are enqueued. Each entry holds:
  - base address ea & ~(NB-1);
  - D and S;
  - flag two = crossing.
- Drain state machine per head entry:
  - BEAT0: mem_addr = base, mem_wdata = D low half, mem_wstrb = S low half.
    - On mem_ready: if two, go to BEAT1; else pop and stay in BEAT0.
  - BEAT1: mem_addr = base + NB (wraps), mem_wdata = D high half, mem_wstrb = S high half.
    - On mem_ready: pop and return to BEAT0.
- mem_valid = !empty. Once asserted, mem_valid, mem_addr, mem_wdata and mem_wstrb hold stable until mem_ready.
- Beats issue strictly in acceptance order. No merging, no reordering.
- Same-cycle push and pop leaves count unchanged. Pointers wrap modulo DEPTH.
- Errored requests never affect count or the FIFO.

## Timing
- Reset values (asynchronous, immediate on rst_n low):
  - count=0, empty=1, in_ready=1, mem_valid=0;
  - err_valid=0, err_cause=0, err_addr=0;
  - pointers=0, drain state BEAT0.
- Reset mid-operation discards all entries, including a half-issued split store.
- Latency: a store accepted in cycle N drives mem_valid at the earliest in cycle N+1. There is no combinational in_* → mem_* path.
- err_valid is registered: it pulses for exactly cycle N+1 after the accepting cycle N. Back-to-back errors give back-to-back pulses.
- Throughput: one beat per cycle while mem_ready=1. A split store occupies two consecutive beats.
- in_ready deasserts in the cycle after count reaches DEPTH. It reasserts the cycle after a pop, and depends on registered count only.

## Test plan
- SW, base 0x1000, imm 4, data 0xDEADBEEF, mem_ready=1 → next cycle mem_addr 0x1004, wdata 0xDEADBEEF, wstrb 1111, single beat, count back to 0.
- SB, base 0x1000, imm 3, data 0x12345678 → mem_addr 0x1000, wdata 0x78000000, wstrb 1000. SH at ea 0x1001, data 0xBEEF → wdata 0x00BEEF00, wstrb 0110.
- SPLIT_MISALIGNED=1, SW at ea 0x1002, data 0xAABBCCDD → beat0 addr 0x1000, wdata 0xCCDD0000, wstrb 1100; then beat1 addr 0x1004, wdata 0x0000AABB, wstrb 0011. Hold mem_ready low 3 cycles in BEAT1 → outputs stable.
- SPLIT_MISALIGNED=0, same store → err_valid one cycle, cause 01, err_addr 0x1002, no mem_valid. func3=100 → cause 10, count stays 0.
- mem_ready=0, push 4 SWs to 0x0, 0x4, 0x8, 0xC → count 4, in_ready low, 5th in_valid ignored. Release mem_ready → drain in order. At count 2, push and pop in the same cycle → count stays 2.
- Wrap: base 0xFFFFFFFC, imm 8, SW → addr 0x4. Split SW at ea 0xFFFFFFFE → beat1 addr 0x0. Assert rst_n low between beat0 and beat1 → mem_valid 0 immediately, empty=1, no beat1 after release.

Source files
------------

// File: rtl/store_buffer.sv
// store_buffer: computes store effective addresses, lane-aligns data and strobes,
// queues stores in an in-order FIFO and drains them to memory one beat at a time.
// Word-crossing stores are either split into two beats or rejected with an error.
module store_buffer #(
    parameter int XLEN             = 32,
    parameter int DEPTH            = 4,
    parameter bit SPLIT_MISALIGNED = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [XLEN-1:0]            in_base,
    input  logic [XLEN-1:0]            in_imm,
    input  logic [XLEN-1:0]            in_data,
    input  logic [2:0]                 in_func3,
    output logic                       mem_valid,
    input  logic                       mem_ready,
    output logic [XLEN-1:0]            mem_addr,
    output logic [XLEN-1:0]            mem_wdata,
    output logic [XLEN/8-1:0]          mem_wstrb,
    output logic                       err_valid,
    output logic [1:0]                 err_cause,
    output logic [XLEN-1:0]            err_addr,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty
);

    localparam int NB = XLEN / 8;
    localparam int OB = $clog2(NB);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    typedef enum logic {BEAT0, BEAT1} state_t;

    state_t              state_q;
    logic [CW-1:0]       count_q, count_d;
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic                err_valid_q, err_valid_d;
    logic [1:0]          err_cause_q, err_cause_d;
    logic [XLEN-1:0]     err_addr_q, err_addr_d;

    logic [XLEN-1:0]     ent_base_q [DEPTH];
    logic [2*XLEN-1:0]   ent_data_q [DEPTH];
    logic [2*NB-1:0]     ent_strb_q [DEPTH];
    logic [DEPTH-1:0]    ent_two_q;

    logic [XLEN-1:0]     ea, line_addr, masked;
    logic [OB-1:0]       off;
    logic [3:0]          sz;
    logic [4:0]          end_byte;
    logic [NB-1:0]       size_mask;
    logic [2*XLEN-1:0]   d_vec;
    logic [2*NB-1:0]     s_vec;
    logic                crossing, illegal, rej_cross, accept, push, pop, err_hit;

    // Request decode: effective address, size, lane alignment and error classification.
    always_comb begin
        ea        = in_base + in_imm;
        off       = ea[OB-1:0];
        line_addr = {ea[XLEN-1:OB], {OB{1'b0}}};
        sz        = 4'd1 << in_func3[1:0];
        end_byte  = 5'(off) + 5'(sz);
        crossing  = (end_byte > 5'(NB));
        illegal   = in_func3[2] | ((XLEN == 32) && (in_func3[1:0] == 2'b11));
        masked    = '0;
        size_mask = '0;
        for (int b = 0; b < NB; b++) begin
            if (4'(b) < sz) begin
                masked[8*b +: 8] = in_data[8*b +: 8];
                size_mask[b]     = 1'b1;
            end
        end
        d_vec     = {{XLEN{1'b0}}, masked} << {off, 3'b000};
        s_vec     = {{NB{1'b0}}, size_mask} << off;
        rej_cross = crossing & ~SPLIT_MISALIGNED;
        accept    = in_valid & in_ready;
        push      = accept & ~illegal & ~rej_cross;
        err_hit   = accept & (illegal | rej_cross);
    end

    // Head-of-queue beat selection; outputs depend only on registered state.
    always_comb begin
        mem_valid = (count_q != '0);
        mem_addr  = ent_base_q[rd_ptr_q];
        mem_wdata = ent_data_q[rd_ptr_q][XLEN-1:0];
        mem_wstrb = ent_strb_q[rd_ptr_q][NB-1:0];
        if (state_q == BEAT1) begin
            mem_addr  = ent_base_q[rd_ptr_q] + XLEN'(NB);
            mem_wdata = ent_data_q[rd_ptr_q][2*XLEN-1:XLEN];
            mem_wstrb = ent_strb_q[rd_ptr_q][2*NB-1:NB];
        end
        pop = mem_valid & mem_ready & ((state_q == BEAT1) | ~ent_two_q[rd_ptr_q]);
    end

    // Next-state for occupancy, pointers and the registered error pulse.
    always_comb begin
        count_d     = count_q + CW'(push) - CW'(pop);
        wr_ptr_d    = wr_ptr_q + PW'(push);
        rd_ptr_d    = rd_ptr_q + PW'(pop);
        err_valid_d = err_hit;
        err_cause_d = 2'b00;
        err_addr_d  = '0;
        if (err_hit) begin
            err_cause_d = illegal ? 2'b10 : 2'b01;
            err_addr_d  = ea;
        end
    end

    // Control registers; cleared asynchronously so a reset discards all queued work.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            err_valid_q <= 1'b0;
            err_cause_q <= 2'b00;
            err_addr_q  <= '0;
        end else begin
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            err_valid_q <= err_valid_d;
            err_cause_q <= err_cause_d;
            err_addr_q  <= err_addr_d;
        end
    end

    // Drain FSM: a two-beat entry stays at the head until its second beat is taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BEAT0;
        end else if (mem_valid && mem_ready) begin
            case (state_q)
                BEAT0:   state_q <= ent_two_q[rd_ptr_q] ? BEAT1 : BEAT0;
                BEAT1:   state_q <= BEAT0;
                default: state_q <= BEAT0;
            endcase
        end
    end

    // FIFO payload storage; written only on push, validity is tracked by count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            ent_base_q[wr_ptr_q] <= line_addr;
            ent_data_q[wr_ptr_q] <= d_vec;
            ent_strb_q[wr_ptr_q] <= s_vec;
            ent_two_q[wr_ptr_q]  <= crossing;
        end
    end

    assign in_ready  = (count_q < CW'(DEPTH));
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign err_valid = err_valid_q;
    assign err_cause = err_cause_q;
    assign err_addr  = err_addr_q;

endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: table-driven and scoreboard-based bench for store_buffer.
`timescale 1ns/1ps
module tb_store_buffer;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
    } beat_t;

    typedef struct packed {
        logic [1:0]  cause;
        logic [31:0] addr;
    } err_t;

    typedef struct {
        logic [31:0] base;
        logic [31:0] imm;
        logic [31:0] data;
        logic [2:0]  f3;
        bit          is_err;
        logic [1:0]  cause;
        beat_t       b0;
        bit          two;
        beat_t       b1;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid, in_valid_ns;
    logic [31:0] in_base, in_imm, in_data;
    logic [2:0]  in_func3;
    logic        mem_ready, mem_ready_ns;

    logic        in_ready, mem_valid, err_valid, empty;
    logic [31:0] mem_addr, mem_wdata, err_addr;
    logic [3:0]  mem_wstrb;
    logic [1:0]  err_cause;
    logic [2:0]  count;

    logic        in_ready_ns, mem_valid_ns, err_valid_ns, empty_ns;
    logic [31:0] mem_addr_ns, mem_wdata_ns, err_addr_ns;
    logic [3:0]  mem_wstrb_ns;
    logic [1:0]  err_cause_ns;
    logic [2:0]  count_ns;

    int    checks = 0;
    int    errors = 0;
    bit    rnd_en = 1'b0;
    beat_t beat_q[$];
    err_t  err_q[$];
    vec_t  vt[14];

    always #5 clk = ~clk;

    store_buffer #(.XLEN(32), .DEPTH(4), .SPLIT_MISALIGNED(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_base(in_base), .in_imm(in_imm), .in_data(in_data), .in_func3(in_func3),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .err_valid(err_valid),
        .err_cause(err_cause), .err_addr(err_addr), .count(count), .empty(empty)
    );

    store_buffer #(.XLEN(32), .DEPTH(4), .SPLIT_MISALIGNED(1'b0)) dut_ns (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_ns), .in_ready(in_ready_ns),
        .in_base(in_base), .in_imm(in_imm), .in_data(in_data), .in_func3(in_func3),
        .mem_valid(mem_valid_ns), .mem_ready(mem_ready_ns), .mem_addr(mem_addr_ns),
        .mem_wdata(mem_wdata_ns), .mem_wstrb(mem_wstrb_ns), .err_valid(err_valid_ns),
        .err_cause(err_cause_ns), .err_addr(err_addr_ns), .count(count_ns), .empty(empty_ns)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] b, i, d, input logic [2:0] f,
                                input bit e, input logic [1:0] c,
                                input logic [31:0] a0, w0, input logic [3:0] s0,
                                input bit t, input logic [31:0] a1, w1, input logic [3:0] s1);
        vec_t v;
        v.base = b; v.imm = i; v.data = d; v.f3 = f; v.is_err = e; v.cause = c;
        v.b0 = '{a0, w0, s0}; v.two = t; v.b1 = '{a1, w1, s1};
        return v;
    endfunction

    // Reference model for the splitting instance: byte-by-byte placement.
    task automatic model(input logic [31:0] b, i, d, input logic [2:0] f);
        logic [31:0] ea;
        logic [63:0] dv;
        logic [7:0]  sv;
        beat_t       x;
        int          off, sz;
        ea  = b + i;
        off = int'(ea[1:0]);
        if (f[2] || f[1:0] == 2'b11) begin
            err_q.push_back('{2'b10, ea});
            return;
        end
        sz = 1 << f[1:0];
        dv = '0;
        sv = '0;
        for (int k = 0; k < sz; k++) begin
            dv[8*(off+k) +: 8] = d[8*k +: 8];
            sv[off+k]          = 1'b1;
        end
        x.addr  = {ea[31:2], 2'b00};
        x.wdata = dv[31:0];
        x.strb  = sv[3:0];
        beat_q.push_back(x);
        if (off + sz > 4) begin
            x.addr  = x.addr + 32'd4;
            x.wdata = dv[63:32];
            x.strb  = sv[7:4];
            beat_q.push_back(x);
        end
    endtask

    task automatic send(input bit ns, input logic [31:0] b, i, d, input logic [2:0] f);
        int n;
        @(negedge clk);
        in_base = b; in_imm = i; in_data = d; in_func3 = f;
        if (ns) in_valid_ns = 1'b1; else in_valid = 1'b1;
        n = 0;
        while (!(ns ? in_ready_ns : in_ready) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            checks++; errors++;
            $display("FAIL send_timeout: in_ready stuck at 0 expected 1");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_valid_ns = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (!empty && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) begin
            checks++; errors++;
            $display("FAIL drain_timeout: empty %0b expected 1", empty);
        end
        repeat (2) @(negedge clk);
        chk("beats_left", 64'(beat_q.size()), 64'd0);
        chk("errs_left", 64'(err_q.size()), 64'd0);
    endtask

    // Scoreboard monitor: compare each accepted beat and each error pulse in order.
    always @(negedge clk) begin
        beat_t eb;
        err_t  ee;
        if (rst_n && mem_valid && mem_ready) begin
            if (beat_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_beat: addr %0h wdata %0h expected no beat", mem_addr, mem_wdata);
            end else begin
                eb = beat_q.pop_front();
                chk("beat_addr", 64'(mem_addr), 64'(eb.addr));
                chk("beat_wdata", 64'(mem_wdata), 64'(eb.wdata));
                chk("beat_wstrb", 64'(mem_wstrb), 64'(eb.strb));
            end
        end
        if (rst_n && err_valid) begin
            if (err_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_err: cause %0h addr %0h expected no error", err_cause, err_addr);
            end else begin
                ee = err_q.pop_front();
                chk("err_cause", 64'(err_cause), 64'(ee.cause));
                chk("err_addr", 64'(err_addr), 64'(ee.addr));
            end
        end
    end

    // Random backpressure during the random phase.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd_en) mem_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vt[0]  = mk(32'h1000, 32'h4, 32'hDEADBEEF, 3'b010, 0, 2'b00, 32'h1004, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0);
        vt[1]  = mk(32'h1000, 32'h3, 32'h12345678, 3'b000, 0, 2'b00, 32'h1000, 32'h78000000, 4'h8, 0, 0, 0, 0);
        vt[2]  = mk(32'h1000, 32'h1, 32'h0000BEEF, 3'b001, 0, 2'b00, 32'h1000, 32'h00BEEF00, 4'h6, 0, 0, 0, 0);
        vt[3]  = mk(32'h1000, 32'h2, 32'hAABBCCDD, 3'b010, 0, 2'b00, 32'h1000, 32'hCCDD0000, 4'hC,
                    1, 32'h1004, 32'h0000AABB, 4'h3);
        vt[4]  = mk(32'hFFFFFFFC, 32'h8, 32'h11223344, 3'b010, 0, 2'b00, 32'h4, 32'h11223344, 4'hF, 0, 0, 0, 0);
        vt[5]  = mk(32'h1003, 32'h0, 32'h00005566, 3'b001, 0, 2'b00, 32'h1000, 32'h66000000, 4'h8,
                    1, 32'h1004, 32'h00000055, 4'h1);
        vt[6]  = mk(32'h2000, 32'hFFFFFFFF, 32'hFFFFFFAB, 3'b000, 0, 2'b00, 32'h1FFC, 32'hAB000000, 4'h8, 0, 0, 0, 0);
        vt[7]  = mk(32'h3002, 32'h0, 32'h12345678, 3'b001, 0, 2'b00, 32'h3000, 32'h56780000, 4'hC, 0, 0, 0, 0);
        vt[8]  = mk(32'h10, 32'h4, 32'h0, 3'b100, 1, 2'b10, 32'h14, 0, 0, 0, 0, 0, 0);
        vt[9]  = mk(32'h20, 32'h0, 32'h0, 3'b011, 1, 2'b10, 32'h20, 0, 0, 0, 0, 0, 0);
        vt[10] = mk(32'hFFFFFFFE, 32'h0, 32'h01020304, 3'b010, 0, 2'b00, 32'hFFFFFFFC, 32'h03040000, 4'hC,
                    1, 32'h0, 32'h00000102, 4'h3);
        vt[11] = mk(32'h40, 32'h1, 32'h000000A5, 3'b000, 0, 2'b00, 32'h40, 32'h0000A500, 4'h2, 0, 0, 0, 0);
        vt[12] = mk(32'h50, 32'h0, 32'h0, 3'b110, 1, 2'b10, 32'h50, 0, 0, 0, 0, 0, 0);
        vt[13] = mk(32'h60, 32'h0, 32'hFFFF1234, 3'b001, 0, 2'b00, 32'h60, 32'h00001234, 4'h3, 0, 0, 0, 0);

        in_valid = 1'b0; in_valid_ns = 1'b0;
        in_base = '0; in_imm = '0; in_data = '0; in_func3 = 3'b010;
        mem_ready = 1'b1; mem_ready_ns = 1'b1;

        // Reset state
        #2;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_mem_valid", 64'(mem_valid), 64'd0);
        chk("rst_err_valid", 64'(err_valid), 64'd0);
        chk("rst_err_cause", 64'(err_cause), 64'd0);
        chk("rst_err_addr", 64'(err_addr), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Table vectors with memory always ready
        for (int k = 0; k < 14; k++) begin
            if (vt[k].is_err) begin
                err_q.push_back('{vt[k].cause, vt[k].b0.addr});
            end else begin
                beat_q.push_back(vt[k].b0);
                if (vt[k].two) beat_q.push_back(vt[k].b1);
            end
            send(1'b0, vt[k].base, vt[k].imm, vt[k].data, vt[k].f3);
            if (k == 0) chk("first_latency_valid", 64'(mem_valid), 64'd1);
        end
        wait_drain();
        chk("table_count_zero", 64'(count), 64'd0);

        // Split store stalled in its second beat
        @(posedge clk); #1 mem_ready = 1'b0;
        beat_q.push_back('{32'h1000, 32'hCCDD0000, 4'hC});
        beat_q.push_back('{32'h1004, 32'h0000AABB, 4'h3});
        send(1'b0, 32'h1000, 32'h2, 32'hAABBCCDD, 3'b010);
        repeat (2) begin
            @(negedge clk);
            chk("stall_b0_valid", 64'(mem_valid), 64'd1);
            chk("stall_b0_addr", 64'(mem_addr), 64'h1000);
        end
        @(posedge clk); #1 mem_ready = 1'b1;
        @(posedge clk); #1 mem_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("stall_b1_valid", 64'(mem_valid), 64'd1);
            chk("stall_b1_addr", 64'(mem_addr), 64'h1004);
            chk("stall_b1_wdata", 64'(mem_wdata), 64'h0000AABB);
            chk("stall_b1_wstrb", 64'(mem_wstrb), 64'h3);
        end
        @(posedge clk); #1 mem_ready = 1'b1;
        wait_drain();

        // Non-splitting instance: crossing rejected, illegal func3, in-word misaligned ok
        send(1'b1, 32'h1000, 32'h2, 32'hAABBCCDD, 3'b010);
        chk("ns_err_valid", 64'(err_valid_ns), 64'd1);
        chk("ns_err_cause", 64'(err_cause_ns), 64'h1);
        chk("ns_err_addr", 64'(err_addr_ns), 64'h1002);
        chk("ns_err_no_beat", 64'(mem_valid_ns), 64'd0);
        chk("ns_err_count", 64'(count_ns), 64'd0);
        @(posedge clk); #1;
        chk("ns_err_pulse_end", 64'(err_valid_ns), 64'd0);
        chk("ns_err_still_no_beat", 64'(mem_valid_ns), 64'd0);
        send(1'b1, 32'h30, 32'h0, 32'h0, 3'b100);
        chk("ns_ill_valid", 64'(err_valid_ns), 64'd1);
        chk("ns_ill_cause", 64'(err_cause_ns), 64'h2);
        chk("ns_ill_count", 64'(count_ns), 64'd0);
        send(1'b1, 32'h1000, 32'h1, 32'h0000BEEF, 3'b001);
        chk("ns_sh_valid", 64'(mem_valid_ns), 64'd1);
        chk("ns_sh_addr", 64'(mem_addr_ns), 64'h1000);
        chk("ns_sh_wdata", 64'(mem_wdata_ns), 64'h00BEEF00);
        chk("ns_sh_wstrb", 64'(mem_wstrb_ns), 64'h6);
        chk("ns_sh_no_err", 64'(err_valid_ns), 64'd0);

        // Back-to-back errors on the splitting instance
        err_q.push_back('{2'b10, 32'h70});
        err_q.push_back('{2'b10, 32'h80});
        send(1'b0, 32'h70, 32'h0, 32'h0, 3'b111);
        chk("b2b_err1_valid", 64'(err_valid), 64'd1);
        send(1'b0, 32'h80, 32'h0, 32'h0, 3'b011);
        chk("b2b_err2_valid", 64'(err_valid), 64'd1);
        chk("b2b_err2_addr", 64'(err_addr), 64'h80);
        @(posedge clk); #1;
        chk("b2b_err_end", 64'(err_valid), 64'd0);
        chk("b2b_count", 64'(count), 64'd0);

        // Full FIFO, ignored request, then push and pop in the same cycle
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            beat_q.push_back('{32'(4 * i), 32'h11110000 + 32'(i), 4'hF});
            send(1'b0, 32'(4 * i), 32'h0, 32'h11110000 + 32'(i), 3'b010);
        end
        chk("full_count", 64'(count), 64'd4);
        chk("full_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        in_base = 32'h100; in_imm = 32'h0; in_data = 32'h55555555; in_func3 = 3'b010;
        in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("full_ignored_count", 64'(count), 64'd4);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        mem_ready = 1'b1;
        @(posedge clk); #1;
        chk("drain_count3", 64'(count), 64'd3);
        @(posedge clk); #1;
        chk("drain_count2", 64'(count), 64'd2);
        beat_q.push_back('{32'h200, 32'h77777777, 4'hF});
        in_base = 32'h200; in_imm = 32'h0; in_data = 32'h77777777; in_func3 = 3'b010;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("push_pop_count", 64'(count), 64'd2);
        wait_drain();

        // Random stores under random backpressure
        rnd_en = 1'b1;
        for (int r = 0; r < 40; r++) begin
            logic [31:0] rb, ri, rd;
            logic [2:0]  rf;
            rb = (r % 5 == 0) ? 32'hFFFFFFF8 : 32'h1000 + 32'($urandom_range(0, 15));
            ri = 32'($urandom_range(0, 7));
            rd = $urandom;
            rf = 3'($urandom_range(0, 4));
            model(rb, ri, rd, rf);
            send(1'b0, rb, ri, rd, rf);
        end
        rnd_en = 1'b0;
        @(posedge clk); #2 mem_ready = 1'b1;
        wait_drain();

        // Reset between the two beats of a wrapping split store
        @(posedge clk); #1 mem_ready = 1'b0;
        beat_q.push_back('{32'hFFFFFFFC, 32'h03040000, 4'hC});
        send(1'b0, 32'hFFFFFFFE, 32'h0, 32'h01020304, 3'b010);
        @(posedge clk); #1 mem_ready = 1'b1;
        @(posedge clk); #1 mem_ready = 1'b0;
        @(negedge clk);
        chk("wrap_b1_valid", 64'(mem_valid), 64'd1);
        chk("wrap_b1_addr", 64'(mem_addr), 64'h0);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_mem_valid", 64'(mem_valid), 64'd0);
        chk("midrst_empty", 64'(empty), 64'd1);
        chk("midrst_count", 64'(count), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        mem_ready = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("postrst_no_beat", 64'(mem_valid), 64'd0);
        end
        chk("postrst_queue", 64'(beat_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
